// File: rtl/uart_defs_pkg.sv
// Shared definitions for the UART RX dequeue-side controller.
//   RxCtrlState_t  : read sequencer states
//   RX_IRQ_*       : bit positions inside irq_status / irq_mask / irq_clr
//   RxIrqStatus_t  : packed view of the 3-bit status vector
package uart_defs;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    RESP  = 2'd2
  } RxCtrlState_t;

  localparam int unsigned RX_IRQ_THRESH  = 0;
  localparam int unsigned RX_IRQ_TIMEOUT = 1;
  localparam int unsigned RX_IRQ_OVERRUN = 2;

  typedef struct packed {
    logic overrun;
    logic timeout;
    logic thresh;
  } RxIrqStatus_t;

endpackage

// File: rtl/uart_rx_timeout.sv
// Character-timeout tick counter.
//   clk, rst : clock, async active-high reset
//   clr      : restart counting from zero (priority over tick)
//   tick     : one baud period elapsed
//   limit    : ticks until firing; 0 disables
//   fire     : one-cycle pulse on the tick that reaches the limit; the
//              counter then saturates until the next clr
module uart_rx_timeout #(
  parameter int unsigned TO_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            tick,
  input  logic [TO_W-1:0] limit,
  output logic            fire
);

  logic [TO_W-1:0] cnt;
  logic            sat;
  logic            armed;

  assign armed = tick & ~clr & ~sat & (limit != '0);
  // >= rather than == so a limit lowered below the running count still fires
  assign fire  = armed & (cnt >= limit - TO_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      sat <= 1'b0;
    end else if (clr) begin
      cnt <= '0;
      sat <= 1'b0;
    end else if (fire) begin
      sat <= 1'b1;
    end else if (armed) begin
      cnt <= cnt + TO_W'(1);
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Dequeue-side controller of the UART RX async FIFO.
// Tracks occupancy, turns single-byte register reads into FIFO pops, and
// raises threshold / character-timeout / overrun status plus FIFO flush.
//   enable, rx_push, baud_tick          : RX path control and events
//   fifo_data/valid/ready, fifo_flush   : FIFO dequeue port
//   thresh, timeout_bits                : level threshold, idle timeout
//   rd_req, rd_data, rd_valid, rd_empty : register-side read handshake
//   flush_req                           : flush request
//   irq_mask, irq_clr, irq_status, irq  : {overrun, timeout, thresh}
//   level                               : current occupancy
module uart_rx_ctrl
  import uart_defs::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned TO_W  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   rx_push,
  input  logic                   baud_tick,
  input  logic [7:0]             fifo_data,
  input  logic                   fifo_valid,
  output logic                   fifo_ready,
  output logic                   fifo_flush,
  input  logic [$clog2(DEPTH):0] thresh,
  input  logic [TO_W-1:0]        timeout_bits,
  input  logic                   rd_req,
  output logic [7:0]             rd_data,
  output logic                   rd_valid,
  output logic                   rd_empty,
  input  logic                   flush_req,
  input  logic [2:0]             irq_mask,
  input  logic [2:0]             irq_clr,
  output logic [2:0]             irq_status,
  output logic                   irq,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned LW = $clog2(DEPTH) + 1;

  RxCtrlState_t state, state_nx;
  logic         push, pop, push_ok, ovr_set, to_fire, to_clr;
  logic         ld_data, ld_empty, empty_q, thr_hit;
  logic [2:0]   sticky_q, sticky_set;
  RxIrqStatus_t status;

  assign push    = rx_push & enable;
  assign pop     = fifo_valid & fifo_ready;
  assign push_ok = push & (level < LW'(DEPTH));
  assign ovr_set = push & (level == LW'(DEPTH)) & ~flush_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  level <= '0;
    else if (flush_req)       level <= '0;
    else if (push_ok & ~pop)  level <= level + LW'(1);
    else if (~push_ok & pop)  level <= level - LW'(1);
  end

  always_comb begin
    state_nx   = state;
    fifo_ready = 1'b0;
    ld_data    = 1'b0;
    ld_empty   = 1'b0;
    case (state)
      IDLE: begin
        if (rd_req) begin
          if (level != '0) begin
            state_nx = FETCH;
          end else begin
            state_nx = RESP;
            ld_empty = 1'b1;
          end
        end
      end
      FETCH: begin
        fifo_ready = 1'b1;
        if (fifo_valid) begin
          ld_data  = 1'b1;
          state_nx = RESP;
        end
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (flush_req) begin
      state_nx = IDLE;
      ld_data  = 1'b0;
      ld_empty = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rd_data    <= '0;
      empty_q    <= 1'b0;
      fifo_flush <= 1'b0;
    end else begin
      state      <= state_nx;
      fifo_flush <= flush_req;
      if (ld_data) begin
        rd_data <= fifo_data;
        empty_q <= 1'b0;
      end else if (ld_empty) begin
        rd_data <= '0;
        empty_q <= 1'b1;
      end
    end
  end

  assign rd_valid = (state == RESP);
  assign rd_empty = rd_valid & empty_q;

  assign to_clr = push | pop | flush_req | (level == '0) | ~enable;

  uart_rx_timeout #(
    .TO_W (TO_W)
  ) u_timeout (
    .clk   (clk),
    .rst   (rst),
    .clr   (to_clr),
    .tick  (baud_tick),
    .limit (timeout_bits),
    .fire  (to_fire)
  );

  always_comb begin
    sticky_set                 = '0;
    sticky_set[RX_IRQ_TIMEOUT] = to_fire;
    sticky_set[RX_IRQ_OVERRUN] = ovr_set;
  end

  // Set wins over clear. Bit 0 never sets, so irq_clr[0] is a no-op and the
  // thresh status stays purely level-driven.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sticky_q <= '0;
    else     sticky_q <= sticky_set | (sticky_q & ~irq_clr);
  end

  assign thr_hit = (thresh != '0) & (level >= thresh);

  always_comb begin
    status        = RxIrqStatus_t'(sticky_q);
    status.thresh = status.thresh | thr_hit;
  end

  assign irq_status = status;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) irq <= 1'b0;
    else     irq <= |(irq_status & irq_mask);
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
module tb_uart_rx_ctrl;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned TO_W  = 8;
  localparam int unsigned LW    = $clog2(DEPTH) + 1;

  logic            clk = 1'b0;
  logic            rst, enable, rx_push, baud_tick;
  logic [7:0]      fifo_data;
  logic            fifo_valid, fifo_ready, fifo_flush;
  logic [LW-1:0]   thresh;
  logic [TO_W-1:0] timeout_bits;
  logic            rd_req;
  logic [7:0]      rd_data;
  logic            rd_valid, rd_empty, flush_req;
  logic [2:0]      irq_mask, irq_clr, irq_status;
  logic            irq;
  logic [LW-1:0]   level;

  always #5 clk = ~clk;

  uart_rx_ctrl #(
    .DEPTH (DEPTH),
    .TO_W  (TO_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .rx_push      (rx_push),
    .baud_tick    (baud_tick),
    .fifo_data    (fifo_data),
    .fifo_valid   (fifo_valid),
    .fifo_ready   (fifo_ready),
    .fifo_flush   (fifo_flush),
    .thresh       (thresh),
    .timeout_bits (timeout_bits),
    .rd_req       (rd_req),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .rd_empty     (rd_empty),
    .flush_req    (flush_req),
    .irq_mask     (irq_mask),
    .irq_clr      (irq_clr),
    .irq_status   (irq_status),
    .irq          (irq),
    .level        (level)
  );

  // Reference model: FIFO contents as a queue, read transaction as scheduled
  // cycle numbers, timeout as "ticks seen since last activity".
  byte unsigned q[$];
  byte unsigned push_byte;
  byte unsigned m_rdata;
  int  m_level, m_tcnt, cyc_n, pop_at, resp_at, flush_at;
  bit  m_ovr, m_to, m_irq, m_sat, m_empty, stall;
  int  n_chk, n_pass, n_fail;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h (cycle %0d)", tag, obs, exp, cyc_n);
    end
  endtask

  function automatic logic [2:0] m_status();
    return {m_ovr, m_to, (thresh != 0) && (m_level >= int'(thresh))};
  endfunction

  task automatic drive_fifo();
    fifo_valid = (q.size() != 0) && !stall;
    fifo_data  = (q.size() != 0) ? q[0] : 8'h00;
  endtask

  task automatic check_outputs();
    check("level",      32'(level),      32'(m_level));
    check("fifo_ready", 32'(fifo_ready), 32'(cyc_n == pop_at));
    check("rd_valid",   32'(rd_valid),   32'(cyc_n == resp_at));
    check("rd_empty",   32'(rd_empty),   32'((cyc_n == resp_at) && m_empty));
    check("rd_data",    32'(rd_data),    32'(m_rdata));
    check("fifo_flush", 32'(fifo_flush), 32'(cyc_n == flush_at));
    check("irq_status", 32'(irq_status), 32'(m_status()));
    check("irq",        32'(irq),        32'(m_irq));
  endtask

  task automatic model_reset();
    q.delete();
    m_level = 0; m_tcnt = 0; m_sat = 0; m_ovr = 0; m_to = 0; m_irq = 0;
    m_rdata = 8'h00; m_empty = 0;
    pop_at = -1; resp_at = -1; flush_at = -1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    model_reset();
    drive_fifo();
    check_outputs();
    rst = 1'b0;
    #1;
    check_outputs();
  endtask

  task automatic step();
    int c, lvl0;
    bit [2:0] st0;
    bit mpush, mpop, idle0, ovr_set, to_set;
    @(posedge clk);
    c       = cyc_n;
    lvl0    = m_level;
    st0     = m_status();
    mpush   = rx_push && enable;
    mpop    = (c == pop_at) && fifo_valid;
    idle0   = (pop_at < c) && (resp_at < c);
    ovr_set = 0;
    to_set  = 0;
    m_irq    = |(st0 & irq_mask);
    flush_at = flush_req ? c + 1 : -1;
    if (flush_req) begin
      q.delete();
      pop_at = -1; resp_at = -1; m_tcnt = 0; m_sat = 0;
    end else begin
      if (c == pop_at) begin
        if (fifo_valid) begin
          m_rdata = q.pop_front();
          m_empty = 0;
          resp_at = c + 1;
          pop_at  = -1;
        end else begin
          pop_at = c + 1;
        end
      end
      if (mpush) begin
        if (lvl0 < DEPTH) q.push_back(push_byte);
        else              ovr_set = 1;
      end
      if (rd_req && idle0) begin
        if (lvl0 == 0) begin
          resp_at = c + 1; m_empty = 1; m_rdata = 8'h00;
        end else begin
          pop_at = c + 1;
        end
      end
      if (mpush || mpop || lvl0 == 0 || !enable) begin
        m_tcnt = 0; m_sat = 0;
      end else if (baud_tick && timeout_bits != 0 && !m_sat) begin
        m_tcnt++;
        if (m_tcnt >= int'(timeout_bits)) begin
          to_set = 1; m_sat = 1;
        end
      end
    end
    m_level = q.size();
    m_ovr = ovr_set | (m_ovr & !irq_clr[2]);
    m_to  = to_set  | (m_to  & !irq_clr[1]);
    cyc_n++;
    #1;
    rx_push = 0; rd_req = 0; flush_req = 0; baud_tick = 0; irq_clr = '0;
    drive_fifo();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic push_one(input byte unsigned b);
    rx_push = 1; push_byte = b;
    step();
  endtask

  task automatic read_one();
    rd_req = 1;
    step();
    for (int k = 0; k < 3; k++) step();
  endtask

  initial begin
    n_chk = 0; n_pass = 0; n_fail = 0; cyc_n = 0;
    rst = 1; enable = 1; rx_push = 0; baud_tick = 0; rd_req = 0; flush_req = 0;
    thresh = '0; timeout_bits = '0; irq_mask = '0; irq_clr = '0;
    push_byte = 0; stall = 0;
    model_reset();
    drive_fifo();
    @(negedge clk);
    do_reset();

    // Reset while the read sequencer waits in FETCH on a stalled FIFO
    push_one(8'h11);
    push_one(8'h22);
    stall = 1; drive_fifo();
    rd_req = 1; step();
    step(); step();
    check("fetch_wait_ready", 32'(fifo_ready), 32'd1);
    do_reset();
    stall = 0; drive_fifo();
    check("rst_level", 32'(level), 32'd0);
    step(); step();

    // Threshold status and its registered irq
    thresh = LW'(3); irq_mask = 3'b001;
    push_one(8'h31); push_one(8'h32); push_one(8'h33);
    check("thr_status", 32'(irq_status), 32'd1);
    check("thr_irq_lag", 32'(irq), 32'd0);
    step();
    check("thr_irq", 32'(irq), 32'd1);
    read_one();
    check("thr_after_read_level", 32'(level), 32'd2);
    check("thr_after_read_bit", 32'(irq_status[0]), 32'd0);
    check("thr_read_data", 32'(rd_data), 32'h31);
    read_one(); read_one();
    thresh = '0;

    // Read at level 0
    rd_req = 1; step();
    check("empty_rd_valid", 32'(rd_valid), 32'd1);
    check("empty_rd_empty", 32'(rd_empty), 32'd1);
    check("empty_rd_data",  32'(rd_data),  32'd0);
    step();

    // Character timeout, saturation, clear, re-arm on new activity
    timeout_bits = TO_W'(4); irq_mask = 3'b010;
    push_one(8'hA5);
    for (int k = 0; k < 3; k++) begin baud_tick = 1; step(); end
    check("to_before_4th", 32'(irq_status[1]), 32'd0);
    baud_tick = 1; step();
    check("to_on_4th", 32'(irq_status[1]), 32'd1);
    for (int k = 0; k < 3; k++) begin baud_tick = 1; step(); end
    irq_clr = 3'b010; step();
    check("to_cleared", 32'(irq_status[1]), 32'd0);
    for (int k = 0; k < 6; k++) begin baud_tick = 1; step(); end
    check("to_saturated", 32'(irq_status[1]), 32'd0);
    push_one(8'h3C);
    for (int k = 0; k < 4; k++) begin baud_tick = 1; step(); end
    check("to_rearmed", 32'(irq_status[1]), 32'd1);
    irq_clr = 3'b010; step();
    read_one(); read_one();
    timeout_bits = '0;

    // Overrun at full FIFO; set beats clear
    irq_mask = 3'b100;
    for (int k = 0; k < 9; k++) push_one(8'(8'h80 + k));
    check("ovr_level", 32'(level), 32'd8);
    check("ovr_set", 32'(irq_status[2]), 32'd1);
    irq_clr = 3'b100; push_one(8'hEE);
    check("ovr_set_wins", 32'(irq_status[2]), 32'd1);
    irq_clr = 3'b100; step();
    check("ovr_cleared", 32'(irq_status[2]), 32'd0);

    // Flush while a read is parked in FETCH
    flush_req = 1; step();
    push_one(8'h44); push_one(8'h55);
    stall = 1; drive_fifo();
    rd_req = 1; step();
    flush_req = 1; step();
    check("flush_pulse", 32'(fifo_flush), 32'd1);
    check("flush_level", 32'(level), 32'd0);
    stall = 0; drive_fifo();
    step(); step();
    rd_req = 1; step();
    check("post_flush_empty", 32'(rd_empty), 32'd1);
    step();

    // Flush coinciding with the pop cycle
    push_one(8'h66);
    rd_req = 1; step();
    flush_req = 1; step();
    step(); step();

    // Randomised traffic against the model
    for (int i = 0; i < 600; i++) begin
      if (i % 100 == 0) begin
        irq_mask     = 3'($urandom);
        thresh       = LW'($urandom_range(0, DEPTH));
        timeout_bits = TO_W'($urandom_range(0, 5));
      end
      enable    = ($urandom_range(0, 19) != 0);
      rx_push   = ($urandom_range(0, 2) == 0);
      push_byte = 8'($urandom);
      rd_req    = ($urandom_range(0, 3) == 0);
      baud_tick = 1'($urandom_range(0, 1));
      flush_req = ($urandom_range(0, 59) == 0);
      irq_clr   = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'b000;
      step();
    end
    enable = 1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
